fpu_ds_arbiter: RTL and testbench
=================================

# fpu_ds_arbiter

Two-thread arbiter and sequencer for the shared iterative FP divide/square-root unit in the 2-thread CPU/FPU core. It accepts div/sqrt requests from thread 0 and thread 1 and grants one at a time, round-robin. It drives the unit's start/operand bus and counts the unit's fixed latency. It returns the result to the owning thread with a one-cycle done pulse, and generates per-thread `stall_div_sqrt` so the requesting pipeline holds until its result returns.

## Interface
- `WIDTH`, 32: operand/result width.
- `DIV_CYCLES`, 20: divide latency N in cycles, 2..32.
- `SQRT_CYCLES`, 12: sqrt latency N in cycles, 2..32.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req0`/`req1`  in  1: thread request, held until that thread's done.
- `op0`/`op1`  in  1: 0 = div, 1 = sqrt; stable while req high.
- `a0`,`b0`/`a1`,`b1`  in  WIDTH: operands; `b` ignored for sqrt.
- `kill0`/`kill1`  in  1: thread flush (interrupt/cancel).
- `fu_result`  in  WIDTH: unit output, valid in the cycle `count`==0 in BUSY.
- `fu_start`  out  1: one-cycle start pulse to the unit.
- `fu_op`  out  1: registered op of the granted request.
- `fu_a`, `fu_b`  out  WIDTH: registered operands.
- `done0`/`done1`  out  1: one-cycle result-valid pulse per thread.
- `result`  out  WIDTH: registered result, valid with a done pulse.
- `stall_div_sqrt0`/`stall_div_sqrt1`  out  1: thread stall.
- `busy`  out  1: unit owned (BUSY or DONE).
- `owner`  out  1: thread owning the unit.
- `count`  out  5: remaining cycles.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE:** if any `reqX` is high and `killX` is low, select a winner:
  - Round-robin pointer `prio` favours its thread on a tie; `prio` resets to 0.
  - Register `fu_op/fu_a/fu_b` from the winner, set `owner`, load `count` = N−1 (N per op), set `fu_start`, go BUSY.
- **BUSY:**
  - `fu_start` is high only in the first BUSY cycle.
  - `count` decrements each cycle.
  - At `count`==0, capture `fu_result` into `result` and go DONE.
- **DONE:**
  - Assert `done[owner]` for one cycle, unless aborted.
  - Toggle `prio` to ¬`owner`; go IDLE.
- `stall_div_sqrt` = `reqX` & ¬`doneX` & ¬`killX`.
  - A requester waiting behind the other thread stays stalled.
- **Kill:**
  - `killX` while X is owner, in BUSY, sets the `abort` flag.
  - The unit is not cancelled; the sequence completes, but no done pulse is issued and `result` is not updated.
  - `abort` clears in DONE.
  - `killX` in IDLE blocks X's grant that cycle.
  - `killX` for the non-owner has no effect on the current operation.
- **Reset values:** all outputs 0, state IDLE, `prio` 0, `abort` 0.
  - Reset mid-operation returns to IDLE next edge with no done pulse; any late `fu_result` is ignored.

## Timing
- Request sampled in IDLE at edge of cycle T.
  - T+1: BUSY, `fu_start`=1, `count`=N−1.
  - T+N: `count`=0, `fu_result` captured.
  - T+N+1: DONE, `doneX`=1, `stall_div_sqrt`X=0.
  - T+N+2: IDLE, next grant decision.
- Request-to-done latency N+1 cycles; back-to-back issue period N+2.
- Requester must drop or change `req` the cycle after its done pulse.
- Simultaneous done and new request from the other thread: the other thread is granted at the following IDLE edge.

## Configuration
- `DS_ARB_FIXED_PRIO_EN`:
  - Defined: thread 0 always wins a tie; `prio` unused. Thread 1 can starve.
  - Undefined (default): round-robin as above.

## Test plan
- Thread 0 div, `a0`=0x40490FDB, `b0`=0x40000000, req at cycle 5 -> `fu_start`=1, `fu_op`=0 at 6; `done0` and `result`=model value at 26; `stall_div_sqrt0` high 5..25.
- `req0`/`req1` both raised at cycle 5 (div, sqrt), after reset -> thread 0 granted first, `done0` at 26; thread 1 `fu_start` at 28, `done1` at 40; `stall_div_sqrt1` high 5..39.
- Both requests again after thread 0 was just served -> thread 1 granted first (round-robin).
- `kill0` while thread 0 owns the unit with `count`=5 -> `stall_div_sqrt0` low that cycle; no `done0`; `result` unchanged; pending `req1` granted after DONE.
- `rst`=1 during BUSY at `count`=7 -> next cycle IDLE, `busy`/`count`/`fu_start`/`done*` = 0; no done pulse follows.
- With `DS_ARB_FIXED_PRIO_EN` defined, three consecutive simultaneous request pairs -> thread 0 is granted on every tie.

Source files
------------

// File: rtl/fpu_ds_arbiter_if.sv
// fpu_ds_arbiter_if: thread request/result and div-sqrt unit bus between the arbiter (slave) and its environment (master)
interface fpu_ds_arbiter_if #(
  parameter int WIDTH = 32
);
  logic req0;
  logic req1;
  logic op0;
  logic op1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic kill0;
  logic kill1;
  logic [WIDTH-1:0] fu_result;
  logic fu_start;
  logic fu_op;
  logic [WIDTH-1:0] fu_a;
  logic [WIDTH-1:0] fu_b;
  logic done0;
  logic done1;
  logic [WIDTH-1:0] result;
  logic stall_div_sqrt0;
  logic stall_div_sqrt1;
  logic busy;
  logic owner;
  logic [4:0] count;
  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, kill0, kill1, fu_result,
    input fu_start, fu_op, fu_a, fu_b, done0, done1, result,
    input stall_div_sqrt0, stall_div_sqrt1, busy, owner, count
  );
  modport slave (
    input req0, req1, op0, op1, a0, b0, a1, b1, kill0, kill1, fu_result,
    output fu_start, fu_op, fu_a, fu_b, done0, done1, result,
    output stall_div_sqrt0, stall_div_sqrt1, busy, owner, count
  );
endinterface

// File: rtl/fpu_ds_arbiter.sv
// fpu_ds_arbiter: two-thread round-robin arbiter/sequencer for the shared FP div/sqrt unit (DS_ARB_FIXED_PRIO_EN: thread 0 wins ties)
module fpu_ds_arbiter #(
  parameter int WIDTH = 32,
  parameter int DIV_CYCLES = 20,
  parameter int SQRT_CYCLES = 12
) (
  input logic clk,
  input logic rst,
  fpu_ds_arbiter_if.slave ds
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [4:0] DIV_LD = 5'(DIV_CYCLES - 1);
  localparam logic [4:0] SQRT_LD = 5'(SQRT_CYCLES - 1);
  state_t state_q, state_d;
  logic owner_q, owner_d;
  logic abort_q, abort_d;
  logic start_q, start_d;
  logic op_q, op_d;
  logic [4:0] count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic v0, v1, win, kill_own;
  assign v0 = ds.req0 && !ds.kill0;
  assign v1 = ds.req1 && !ds.kill1;
  assign kill_own = owner_q ? ds.kill1 : ds.kill0;
`ifdef DS_ARB_FIXED_PRIO_EN
  assign win = !v0;
`else
  logic prio_q;
  always_ff @(posedge clk)
    if (rst) prio_q <= 1'b0;
    else if (state_q == DONE) prio_q <= !owner_q;
  assign win = v0 && v1 ? prio_q : v1;
`endif
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    abort_d = abort_q;
    start_d = 1'b0;
    op_d = op_q;
    count_d = count_q;
    a_d = a_q;
    b_d = b_q;
    result_d = result_q;
    if (state_q == IDLE && (v0 || v1)) begin
      state_d = BUSY;
      owner_d = win;
      start_d = 1'b1;
      op_d = win ? ds.op1 : ds.op0;
      a_d = win ? ds.a1 : ds.a0;
      b_d = win ? ds.b1 : ds.b0;
      count_d = op_d ? SQRT_LD : DIV_LD;
    end else if (state_q == BUSY) begin
      abort_d = abort_q || kill_own;
      count_d = count_q == 5'd0 ? 5'd0 : count_q - 5'd1;
      state_d = count_q == 5'd0 ? DONE : BUSY;
      result_d = count_q == 5'd0 && !abort_d ? ds.fu_result : result_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
      abort_d = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      abort_q <= 1'b0;
      start_q <= 1'b0;
      op_q <= 1'b0;
      count_q <= 5'd0;
      a_q <= '0;
      b_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      abort_q <= abort_d;
      start_q <= start_d;
      op_q <= op_d;
      count_q <= count_d;
      a_q <= a_d;
      b_q <= b_d;
      result_q <= result_d;
    end
  assign ds.fu_start = start_q;
  assign ds.fu_op = op_q;
  assign ds.fu_a = a_q;
  assign ds.fu_b = b_q;
  assign ds.result = result_q;
  assign ds.busy = state_q != IDLE;
  assign ds.owner = owner_q;
  assign ds.count = count_q;
  assign ds.done0 = state_q == DONE && !abort_q && !owner_q;
  assign ds.done1 = state_q == DONE && !abort_q && owner_q;
  assign ds.stall_div_sqrt0 = ds.req0 && !ds.done0 && !ds.kill0;
  assign ds.stall_div_sqrt1 = ds.req1 && !ds.done1 && !ds.kill1;
endmodule

// File: tb/tb_fpu_ds_arbiter.sv
// tb_fpu_ds_arbiter: directed and random checks of fpu_ds_arbiter against a timeline-based job model
module tb_fpu_ds_arbiter;
  localparam int W = 32;
  localparam int ND = 20;
  localparam int NS = 12;
`ifdef DS_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fpu_ds_arbiter_if #(.WIDTH(W)) ds();
  fpu_ds_arbiter #(.WIDTH(W), .DIV_CYCLES(ND), .SQRT_CYCLES(NS)) dut (.clk(clk), .rst(rst), .ds(ds));
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit jv, ja, jo;
  int jg, jn;
  bit m_prio, m_owner, m_op;
  logic [W-1:0] m_a, m_b, m_res;
  bit drop0, drop1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask
  task automatic model_reset();
    jv = 0;
    ja = 0;
    m_prio = 0;
    m_owner = 0;
    m_op = 0;
    m_a = '0;
    m_b = '0;
    m_res = '0;
    drop0 = 0;
    drop1 = 0;
  endtask
  task automatic cycle();
    bit ib, id, e0, e1, v0, v1, w;
    #1;
    ib = jv && cyc > jg && cyc <= jg + jn;
    id = jv && cyc == jg + jn + 1;
    e0 = id && !jo && !ja;
    e1 = id && jo && !ja;
    chk("busy", ds.busy, ib || id);
    chk("fu_start", ds.fu_start, jv && cyc == jg + 1);
    chk("count", ds.count, ib ? jg + jn - cyc : 0);
    chk("done0", ds.done0, e0);
    chk("done1", ds.done1, e1);
    chk("owner", ds.owner, m_owner);
    chk("fu_op", ds.fu_op, m_op);
    chk("fu_a", ds.fu_a, m_a);
    chk("fu_b", ds.fu_b, m_b);
    chk("result", ds.result, m_res);
    chk("stall0", ds.stall_div_sqrt0, ds.req0 && !e0 && !ds.kill0);
    chk("stall1", ds.stall_div_sqrt1, ds.req1 && !e1 && !ds.kill1);
    drop0 |= ds.req0 && (e0 || ds.kill0);
    drop1 |= ds.req1 && (e1 || ds.kill1);
    if (rst) model_reset();
    else begin
      if (ib && (jo ? ds.kill1 : ds.kill0)) ja = 1;
      if (ib && cyc == jg + jn && !ja) m_res = ds.fu_result;
      if (id) begin
        m_prio = !jo;
        jv = 0;
        ja = 0;
      end else if (!jv) begin
        v0 = ds.req0 && !ds.kill0;
        v1 = ds.req1 && !ds.kill1;
        if (v0 || v1) begin
          w = v0 && v1 ? (FIXED ? 1'b0 : m_prio) : v1;
          jv = 1;
          jg = cyc;
          jo = w;
          m_owner = w;
          m_op = w ? ds.op1 : ds.op0;
          m_a = w ? ds.a1 : ds.a0;
          m_b = w ? ds.b1 : ds.b0;
          jn = m_op ? NS : ND;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic tick_inputs();
    ds.fu_result = $urandom;
    if (drop0) begin
      ds.req0 = 0;
      drop0 = 0;
    end
    if (drop1) begin
      ds.req1 = 0;
      drop1 = 0;
    end
  endtask
  task automatic wait_done(input bit t, output int k, output int n);
    k = 0;
    n = 0;
    do begin
      tick_inputs();
      cycle();
      k++;
      n += int'(t ? ds.done0 : ds.done1);
    end while (!(t ? ds.done1 : ds.done0) && k < 80);
  endtask
  task automatic do_reset();
    rst = 1;
    ds.req0 = 0;
    ds.req1 = 0;
    ds.kill0 = 0;
    ds.kill1 = 0;
    cycle();
    rst = 0;
  endtask
  task automatic drain();
    repeat (2) begin
      tick_inputs();
      cycle();
    end
  endtask
  task automatic rand_thread(inout logic req, inout logic op, inout logic [W-1:0] a, inout logic [W-1:0] b, inout bit drop, output logic kill);
    if (drop) begin
      req = 0;
      drop = 0;
    end else if (!req && $urandom_range(0, 3) == 0) begin
      req = 1;
      op = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
    end
    kill = $urandom_range(0, 40) == 0;
  endtask
  initial begin
    int k, n;
    logic r, o, kl;
    logic [W-1:0] x, y;
    bit first;
    model_reset();
    ds.req0 = 0;
    ds.req1 = 0;
    ds.op0 = 0;
    ds.op1 = 0;
    ds.a0 = '0;
    ds.b0 = '0;
    ds.a1 = '0;
    ds.b1 = '0;
    ds.kill0 = 0;
    ds.kill1 = 0;
    ds.fu_result = '0;
    @(posedge clk);
    #1;
    cycle();
    rst = 0;
    ds.req0 = 1;
    ds.op0 = 0;
    ds.a0 = 32'h40490FDB;
    ds.b0 = 32'h40000000;
    wait_done(0, k, n);
    chk("lat_div0", k, ND + 1);
    drain();
    do_reset();
    ds.req0 = 1;
    ds.op0 = 0;
    ds.a0 = $urandom;
    ds.b0 = $urandom;
    ds.req1 = 1;
    ds.op1 = 1;
    ds.a1 = $urandom;
    ds.b1 = $urandom;
    wait_done(0, k, n);
    chk("tie_first0", k, ND + 1);
    wait_done(1, k, n);
    chk("tie_then1", k, NS + 2);
    drain();
    ds.req0 = 1;
    wait_done(0, k, n);
    chk("solo0", k, ND + 1);
    drain();
    ds.req0 = 1;
    ds.req1 = 1;
    first = FIXED ? 1'b0 : 1'b1;
    wait_done(first, k, n);
    chk("rr_first", k, (FIXED ? ND : NS) + 1);
    wait_done(!first, k, n);
    chk("rr_second", k, (FIXED ? NS : ND) + 2);
    drain();
    do_reset();
    ds.req0 = 1;
    ds.req1 = 1;
    k = 0;
    while (!(ds.busy && ds.count == 5) && k < 40) begin
      tick_inputs();
      cycle();
      k++;
    end
    ds.kill0 = 1;
    #1;
    chk("kill_stall0", ds.stall_div_sqrt0, 0);
    cycle();
    ds.kill0 = 0;
    wait_done(1, k, n);
    chk("kill_lat1", k, NS + 7);
    chk("kill_no_done0", n, 0);
    drain();
    ds.req0 = 1;
    ds.op0 = 0;
    k = 0;
    while (!(ds.busy && ds.count == 7) && k < 40) begin
      tick_inputs();
      cycle();
      k++;
    end
    rst = 1;
    ds.req0 = 0;
    cycle();
    rst = 0;
    chk("rst_busy", ds.busy, 0);
    chk("rst_count", ds.count, 0);
    chk("rst_start", ds.fu_start, 0);
    chk("rst_done0", ds.done0, 0);
    repeat (30) begin
      tick_inputs();
      cycle();
    end
    repeat (3000) begin
      ds.fu_result = $urandom;
      r = ds.req0; o = ds.op0; x = ds.a0; y = ds.b0;
      rand_thread(r, o, x, y, drop0, kl);
      ds.req0 = r; ds.op0 = o; ds.a0 = x; ds.b0 = y; ds.kill0 = kl;
      r = ds.req1; o = ds.op1; x = ds.a1; y = ds.b1;
      rand_thread(r, o, x, y, drop1, kl);
      ds.req1 = r; ds.op1 = o; ds.a1 = x; ds.b1 = y; ds.kill1 = kl;
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
